// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and helpers for the register file and its
//                write-pending scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 2**DEF_ADDR_W;

  // Architectural zero register index
  localparam int ZERO_REG = 0;

  // Number of registers addressed by an address of the given width
  function automatic int depth_of(input int addr_w);
    return 2**addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Busy-bit array tracking registers with an outstanding write.
//                Issue sets a bit, writeback clears it, flush clears all.
//                Set beats a same-cycle clear; flush beats set.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        raddr_a,
  input  logic [ADDR_W-1:0]        raddr_b,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int                DEPTH       = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;

  // Per-register set (issue) and clear (writeback on either port) strobes
  for (genvar i = 0; i < DEPTH; i++) begin : g_bits
    assign w_clr[i] = (we0 && (waddr0 == ADDR_W'(i))) ||
                      (we1 && (waddr1 == ADDR_W'(i)));
    assign w_set[i] = iss_vld && (iss_addr == ADDR_W'(i)) && (i != ZERO_REG);
  end

  // Busy-bit update; the zero register can never be set so bit 0 stays low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  // Lookups see a same-cycle writeback as already complete, matching the bypass
  assign busy_a   = (raddr_a != C_ZERO_ADDR) && r_busy[raddr_a] && !w_clr[raddr_a];
  assign busy_b   = (raddr_b != C_ZERO_ADDR) && r_busy[raddr_b] && !w_clr[raddr_b];
  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : 2-read / 2-write register file with same-cycle write-to-read
//                bypass and an integrated RAW-hazard scoreboard. Register 0
//                reads as zero and is never busy. Port 1 wins write conflicts.
//                Optional macro REGFILE_DUMP_EN adds the regs_dump debug port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we0,
  input  logic [ADDR_W-1:0]                 waddr0,
  input  logic [DATA_W-1:0]                 wdata0,
  input  logic                              we1,
  input  logic [ADDR_W-1:0]                 waddr1,
  input  logic [DATA_W-1:0]                 wdata1,
  input  logic [ADDR_W-1:0]                 raddr_a,
  input  logic [ADDR_W-1:0]                 raddr_b,
  output logic [DATA_W-1:0]                 rdata_a,
  output logic [DATA_W-1:0]                 rdata_b,
  output logic                              busy_a,
  output logic                              busy_b,
  input  logic                              iss_vld,
  input  logic [ADDR_W-1:0]                 iss_addr,
  input  logic                              flush,
  output logic [(2**ADDR_W)-1:0]            busy_vec
`ifdef REGFILE_DUMP_EN
  ,
  output logic [DATA_W*(2**ADDR_W)-1:0]     regs_dump
`endif
);

  localparam int                DEPTH       = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;

  // Register writes; port 1 is applied last so it wins a same-address conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (we0 && (waddr0 != C_ZERO_ADDR)) begin
        r_regs[waddr0] <= wdata0;
      end
      if (we1 && (waddr1 != C_ZERO_ADDR)) begin
        r_regs[waddr1] <= wdata1;
      end
    end
  end

  // Read muxes: zero register, then port 1 bypass, then port 0, then array
  always_comb begin
    w_rdata_a = r_regs[raddr_a];
    if (!rst_n || (raddr_a == C_ZERO_ADDR)) begin
      w_rdata_a = '0;
    end else if (we1 && (waddr1 == raddr_a)) begin
      w_rdata_a = wdata1;
    end else if (we0 && (waddr0 == raddr_a)) begin
      w_rdata_a = wdata0;
    end

    w_rdata_b = r_regs[raddr_b];
    if (!rst_n || (raddr_b == C_ZERO_ADDR)) begin
      w_rdata_b = '0;
    end else if (we1 && (waddr1 == raddr_b)) begin
      w_rdata_b = wdata1;
    end else if (we0 && (waddr0 == raddr_b)) begin
      w_rdata_b = wdata0;
    end
  end

  assign rdata_a = w_rdata_a;
  assign rdata_b = w_rdata_b;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .waddr0   (waddr0),
    .we1      (we1),
    .waddr1   (waddr1),
    .iss_vld  (iss_vld),
    .iss_addr (iss_addr),
    .flush    (flush),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_vec (busy_vec)
  );

`ifdef REGFILE_DUMP_EN
  // Flattened view of the stored registers only; no bypass applied
  for (genvar i = 0; i < DEPTH; i++) begin : g_dump
    assign regs_dump[i*DATA_W +: DATA_W] = r_regs[i];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb. Stimulus pushes expected
//                outputs from a behavioural model; a monitor pops and compares
//                them mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        busy_a, busy_b;
  logic        iss_vld;
  logic [4:0]  iss_addr;
  logic        flush;
  logic [31:0] busy_vec;
`ifdef REGFILE_DUMP_EN
  logic [1023:0] regs_dump;
`endif

  regfile_sb #(
    .DATA_W   (32),
    .ADDR_W   (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .iss_vld  (iss_vld),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
`ifdef REGFILE_DUMP_EN
    ,
    .regs_dump(regs_dump)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ba;
    logic        bb;
    logic [31:0] bv;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Behavioural model: architectural register values and pending-write set
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit written(input logic [4:0] a);
    return (we0 && waddr0 == a) || (we1 && waddr1 == a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
    if (we1 && waddr1 == a)  return wdata1;
    if (we0 && waddr0 == a)  return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 1'b0;
    return m_busy[a] && !written(a);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_clock();
    bit nb [32];
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int r = 0; r < 32; r++) begin
      nb[r] = flush ? 1'b0
                    : ((m_busy[r] && !written(5'(r))) ||
                       (iss_vld && iss_addr == 5'(r) && r != 0));
    end
    if (we0 && waddr0 != 5'd0) m_regs[waddr0] = wdata0;
    if (we1 && waddr1 != 5'd0) m_regs[waddr1] = wdata1;
    for (int r = 0; r < 32; r++) m_busy[r] = nb[r];
  endtask

  // One cycle: predict outputs for the current inputs, then clock the model
  task automatic step();
    exp_t e;
    if (!rst_n) model_clear();
    e.ra = exp_read(raddr_a);
    e.rb = exp_read(raddr_b);
    e.ba = exp_busy(raddr_a);
    e.bb = exp_busy(raddr_b);
    for (int r = 0; r < 32; r++) e.bv[r] = rst_n ? m_busy[r] : 1'b0;
    q.push_back(e);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1;  flush = 1'b0;
    we0 = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
    we1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
    raddr_a = 5'd0; raddr_b = 5'd0;
    iss_vld = 1'b0; iss_addr = 5'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rdata_a",  rdata_a,        e.ra);
      check("rdata_b",  rdata_b,        e.rb);
      check("busy_a",   32'(busy_a),    32'(e.ba));
      check("busy_b",   32'(busy_b),    32'(e.bb));
      check("busy_vec", busy_vec,       e.bv);
    end
  end

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    model_clear();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held while writes are attempted: everything reads zero
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hAAAA_5555;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h5555_AAAA;
    raddr_a = 5'd5; raddr_b = 5'd6;
    step();
    step();

    // Zero register ignores writes
    idle();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD_BEEF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hDEAD_BEEF;
    step();
    idle(); raddr_a = 5'd5; raddr_b = 5'd6; step();
    idle(); step();

    // Bypass on port 0, then stored value
    idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; raddr_a = 5'd5; step();
    idle(); raddr_a = 5'd5; step();

    // Dual write conflict, port 1 wins
    idle();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
    raddr_a = 5'd7; raddr_b = 5'd7;
    step();
    idle(); raddr_a = 5'd7; step();

    // Scoreboard issue / hold / writeback
    idle(); iss_vld = 1'b1; iss_addr = 5'd3; step();
    idle(); raddr_b = 5'd3; step();
    idle(); raddr_b = 5'd3; step();
    idle(); raddr_b = 5'd3; we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hCAFE_0003; step();
    idle(); raddr_b = 5'd3; step();

    // Set/clear collision keeps the register busy
    idle(); iss_vld = 1'b1; iss_addr = 5'd9; step();
    idle(); iss_vld = 1'b1; iss_addr = 5'd9; we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99; raddr_a = 5'd9; step();
    idle(); raddr_a = 5'd9; step();

    // Flush beats a simultaneous issue
    idle(); iss_vld = 1'b1; iss_addr = 5'd1;  step();
    idle(); iss_vld = 1'b1; iss_addr = 5'd4;  step();
    idle(); iss_vld = 1'b1; iss_addr = 5'd31; raddr_a = 5'd4; step();
    idle(); flush = 1'b1; iss_vld = 1'b1; iss_addr = 5'd2; raddr_a = 5'd1; step();
    idle(); raddr_a = 5'd2; raddr_b = 5'd31; step();

    // Issue to the zero register never marks it busy
    idle(); iss_vld = 1'b1; iss_addr = 5'd0; step();
    idle(); step();

    // Randomised traffic with occasional flush and mid-run reset
    for (int n = 0; n < 600; n++) begin
      idle();
      rst_n    = ($urandom_range(0, 99) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      we0      = 1'($urandom_range(0, 1));
      waddr0   = rand_addr();
      wdata0   = $urandom;
      we1      = 1'($urandom_range(0, 1));
      waddr1   = rand_addr();
      wdata1   = $urandom;
      raddr_a  = rand_addr();
      raddr_b  = rand_addr();
      iss_vld  = 1'($urandom_range(0, 1));
      iss_addr = rand_addr();
      step();
    end

    idle();
    for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined CPU.
- Provides two read ports and two write ports. Reads are combinational with same-cycle write-to-read bypass; writes occur on the rising clock edge.
- Contains an integrated scoreboard that tracks registers with pending writes so that decode can stall on RAW hazards.
- Register 0 is hard-wired to zero and is never busy.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, write port 0 (ALU writeback).
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, write port 1 (load writeback).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr_a  in  ADDR_W  read address A.
- raddr_b  in  ADDR_W  read address B.
- rdata_a  out  DATA_W  read data A.
- rdata_b  out  DATA_W  read data B.
- busy_a  out  1  register at raddr_a has a pending write.
- busy_b  out  1  register at raddr_b has a pending write.
- iss_vld  in  1  an instruction with a destination is issuing this cycle.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  out  2**ADDR_W  raw scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers are set to 0 and all busy bits to 0.
  - Consequently rdata_a, rdata_b, busy_a, busy_b and busy_vec are all 0 during reset.
  - Reset asserted mid-operation overrides any write, issue or flush in that cycle.
- Write (rising edge):
  - If weN=1 and waddrN≠0, reg[waddrN] is set to wdataN.
  - Writes to address 0 are discarded.
  - Both ports writing the same address in one cycle: port 1 wins.
- Read (combinational, priority order):
  - If raddr=0, return 0.
  - Else if we1 and waddr1=raddr, return wdata1.
  - Else if we0 and waddr0=raddr, return wdata0.
  - Else return reg[raddr].
  - Latency is zero: a read issued in the same cycle as the write returns the new value.
- Scoreboard (rising edge):
  - Next busy bit r = busy[r] & ~clr[r] | set[r].
  - clr[r] = (we0 & waddr0=r) | (we1 & waddr1=r).
  - set[r] = iss_vld & iss_addr=r & r≠0.
  - Issue and writeback to the same register in the same cycle: set wins, so the bit stays busy because the new instruction is still outstanding.
  - flush=1 clears every bit and takes priority over set.
  - Issuing to a register that is already busy leaves it busy (no counting); the pipeline guarantees in-order writeback.
- busy_a / busy_b (combinational):
  - Value = busy[raddr] & ~clr[raddr].
  - A same-cycle writeback therefore shows not-busy, consistent with the bypassed data.
  - Forced to 0 when raddr=0.
- busy_vec is the registered busy state; it does not include the same-cycle clear.

Optional Feature:
- Macro: REGFILE_DUMP_EN.
- When defined:
  - Adds the output port regs_dump (DATA_W*2**ADDR_W bits), the flattened register array with reg[0] in the LSBs, for the debug display.
  - regs_dump is registered state only, with no bypass.
- When undefined: the port is absent and no extra logic is generated.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W;
  - ZERO_REG = 0;
  - a localparam for depth (2**ADDR_W).
- Sub-module rf_scoreboard holds:
  - the busy-bit array with its set/clear/flush logic;
  - the busy_a/busy_b lookup.
- The data array, write logic and bypass muxes stay in regfile_sb.

Test Plan:
- Reset and zero register:
  - Stimulus: assert rst_n=0 mid-write; release; write reg0=0xDEADBEEF.
  - Required: all rdata are 0; reads of address 0 return 0 and busy is 0.
- Bypass:
  - Stimulus: we0=1, waddr0=5, wdata0=0x12345678 with raddr_a=5 in the same cycle.
  - Required: rdata_a=0x12345678 in that cycle and after the edge.
- Dual-write conflict:
  - Stimulus: we0=1 to r7=0x1111 and we1=1 to r7=0x2222 in the same cycle.
  - Required: combinational rdata=0x2222; after the edge reg7=0x2222.
- Scoreboard basic:
  - Stimulus: iss_vld=1 with iss_addr=3; next cycle raddr_b=3; then we1 to r3.
  - Required: busy_b=1 until the writeback cycle, where busy_b=0 combinationally; busy_vec[3]=0 after that edge.
- Set/clear collision:
  - Stimulus: r9 busy; same cycle iss_addr=9 and we0 waddr0=9.
  - Required: busy_vec[9]=1 after the edge.
- Flush:
  - Stimulus: busy bits for r1, r4 and r31 set; flush=1 together with iss_vld for r2.
  - Required: busy_vec=0 after the edge.
